// File: rtl/mem_wait_responder_pkg.sv
// Shared definitions for mem_wait_responder (the project's prj_definition set).
//   state_e          : FSM encoding IDLE / BUSY / RESP
//   WaitCntWidth     : width of the wait-state counter (WAIT_CYCLES 0..15)
//   DefaultDepthLog2 : default log2 of implemented memory words
package mem_wait_responder_pkg;

  localparam int unsigned WaitCntWidth     = 4;
  localparam int unsigned DefaultDepthLog2 = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wait_array.sv
// Word storage for mem_wait_responder.
// 2^DEPTH_LOG2 x DATA_WIDTH array with a synchronous write port and a
// registered read port. The storage itself is never reset; only the read
// register is, so the responder's DATA_OUT comes up as zero.
// Ports:
//   CLK   : clock
//   RST   : synchronous active-high reset (read register only)
//   we    : write enable, commits wdata to addr on the rising edge
//   re    : read enable, loads the read register on the rising edge
//   rzero : with re, load zero instead of the array word
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds until the next read
module mem_wait_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  we,
  input  logic                  re,
  input  logic                  rzero,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [Words];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rzero ? '0 : mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-side responder for the 26-bit address / 32-bit data processor bus.
// Accepts a single-word READ or WRITE request, inserts WAIT_CYCLES wait states
// and completes the access with a one-cycle READY pulse.
// Optional feature: define MEM_WAIT_RESPONDER_RANGE_CHECK_EN to flag addresses
// with nonzero bits above DEPTH_LOG2 (ERR=1 with READY, write suppressed,
// read returns zero). Without it the upper bits alias and ERR is tied 0.
// Ports:
//   CLK      : clock, all state changes on the rising edge
//   RST      : synchronous active-high reset
//   READ     : read request level
//   WRITE    : write request level
//   ADDR     : word address of the request
//   DATA_IN  : write data
//   DATA_OUT : read data, holds the last read value
//   READY    : one-cycle access-complete pulse
//   ERR      : out-of-range flag, valid with READY
module mem_wait_responder
  import mem_wait_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = DefaultDepthLog2,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  READY,
  output logic                  ERR
);

  localparam logic [WaitCntWidth-1:0] WaitLoad = WaitCntWidth'(WAIT_CYCLES);

  state_e                  state_q, state_d;
  logic [WaitCntWidth-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    wr_q, wr_d;
  logic                    ready_q;
  logic                    err_q, err_d;

  // Access actually applied to the array on the edge entering RESP. With
  // WAIT_CYCLES = 0 that edge is the accepting edge, so the live request is
  // used instead of the not-yet-loaded latched copy.
  logic                  go_resp;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  acc_wr;
  logic                  in_range;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    go_resp  = 1'b0;
    acc_addr = addr_q;
    acc_data = data_q;
    acc_wr   = wr_q;

    unique case (state_q)
      IDLE: begin
        // Both requests high is illegal and simply ignored.
        if (READ ^ WRITE) begin
          addr_d   = ADDR;
          data_d   = DATA_IN;
          wr_d     = WRITE;
          acc_addr = ADDR;
          acc_data = DATA_IN;
          acc_wr   = WRITE;
          if (WaitLoad == '0) begin
            cnt_d   = '0;
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            cnt_d   = WaitLoad;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - WaitCntWidth'(1);
        if (cnt_q == WaitCntWidth'(1)) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MEM_WAIT_RESPONDER_RANGE_CHECK_EN
  assign in_range = (acc_addr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
  assign err_d    = go_resp & ~in_range;
`else
  // Upper address bits alias onto the implemented words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[ADDR_WIDTH-1:DEPTH_LOG2];
  assign in_range       = 1'b1;
  assign err_d          = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      ready_q <= go_resp;
      err_q   <= err_d;
    end
  end

  // Array enables are gated by RST so an access aborted by reset never commits.
  logic arr_we;
  logic arr_re;
  assign arr_we = go_resp & acc_wr & in_range & ~RST;
  assign arr_re = go_resp & ~acc_wr & ~RST;

  mem_wait_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .CLK  (CLK),
    .RST  (RST),
    .we   (arr_we),
    .re   (arr_re),
    .rzero(~in_range),
    .addr (acc_addr[DEPTH_LOG2-1:0]),
    .wdata(acc_data),
    .rdata(DATA_OUT)
  );

  assign READY = ready_q;
  assign ERR   = err_q;

endmodule
